// File: rtl/sram_arb_pkg.sv
// rtl/sram_arb_pkg.sv - shared request-field offsets, read tag type and id-width helper for the SRAM arbiter
package sram_arb_pkg;

  // Read tags carry the issuing read-port id; 4 bits covers up to 16 read ports.
  localparam int TAG_ID_W = 4;

  typedef struct packed {
    logic                valid;
    logic [TAG_ID_W-1:0] id;
  } rd_tag_t;

  // Write request word is {mask, addr, data}; data sits at the bottom.
  localparam int DATA_LSB = 0;

  function automatic int addr_lsb(input int data_w);
    return data_w;
  endfunction

  function automatic int mask_lsb(input int addr_w, input int data_w);
    return data_w + addr_w;
  endfunction

  // Width of an index over n items, never less than one bit.
  function automatic int port_id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sram_resp_fifo.sv
// rtl/sram_resp_fifo.sv - synchronous FIFO holding read responses for one read port
module sram_resp_fifo
  import sram_arb_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32
) (
  input  logic              sram_clock,
  input  logic              reset,
  input  logic              wr_valid,
  input  logic [DATA_W-1:0] wr_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [DATA_W-1:0] rd_data
);

  localparam int AW = port_id_w(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [CW-1:0]     count;

  function automatic logic [AW-1:0] bump(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  // Pointer and occupancy tracking; the caller never pushes when full or pops when empty.
  always_ff @(posedge sram_clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_valid) wr_ptr <= bump(wr_ptr);
      if (rd_ready) rd_ptr <= bump(rd_ptr);
      if (wr_valid && !rd_ready)      count <= count + CW'(1);
      else if (rd_ready && !wr_valid) count <= count - CW'(1);
    end
  end

  // Storage array; contents need no reset because occupancy gates visibility.
  always_ff @(posedge sram_clock) begin
    if (wr_valid) mem[wr_ptr] <= wr_data;
  end

  assign rd_valid = (count != '0);
  assign rd_data  = mem[rd_ptr];

endmodule

// File: rtl/sram_rr_arbiter.sv
// rtl/sram_rr_arbiter.sv - round-robin SRAM arbiter with credited read returns; SRAM_ARB_STRICT_WR_PRIO_EN puts writes ahead of reads
module sram_rr_arbiter
  import sram_arb_pkg::*;
#(
  parameter int NUM_W      = 2,
  parameter int NUM_R      = 2,
  parameter int ADDR_W     = 18,
  parameter int DATA_W     = 32,
  parameter int RD_LATENCY = 3,
  parameter int RD_CREDITS = 4
) (
  input  logic                                        sram_clock,
  input  logic                                        reset,
  input  logic [NUM_W-1:0]                            w_valid,
  output logic [NUM_W-1:0]                            w_ready,
  input  logic [NUM_W*((DATA_W/8)+ADDR_W+DATA_W)-1:0] w_din,
  input  logic [NUM_R-1:0]                            r_req_valid,
  output logic [NUM_R-1:0]                            r_req_ready,
  input  logic [NUM_R*ADDR_W-1:0]                     r_req_addr,
  output logic [NUM_R-1:0]                            r_resp_valid,
  input  logic [NUM_R-1:0]                            r_resp_ready,
  output logic [NUM_R*DATA_W-1:0]                     r_resp_data,
  output logic                                        sram_addr_valid,
  input  logic                                        sram_ready,
  output logic [ADDR_W-1:0]                           sram_addr,
  output logic [DATA_W-1:0]                           sram_data_in,
  output logic [(DATA_W/8)-1:0]                       sram_write_mask,
  input  logic [DATA_W-1:0]                           sram_data_out,
  input  logic                                        sram_data_out_valid
);

  localparam int MASK_W   = DATA_W / 8;
  localparam int REQ_W    = MASK_W + ADDR_W + DATA_W;
  localparam int NUM_P    = NUM_W + NUM_R;
  localparam int PTR_W    = port_id_w(NUM_P);
  localparam int RID_W    = port_id_w(NUM_R);
  localparam int CRED_W   = $clog2(RD_CREDITS + 1);
  localparam int ADDR_LSB = addr_lsb(DATA_W);
  localparam int MASK_LSB = mask_lsb(ADDR_W, DATA_W);

  logic [NUM_P-1:0] elig;
  logic [NUM_R-1:0] has_credit;
  logic [PTR_W:0]   pick;
  logic             gnt_vld;
  logic [PTR_W-1:0] gnt_idx;
  logic             rd_grant;
  logic [RID_W-1:0] rd_id;
  rd_tag_t          tag_q [RD_LATENCY];
  rd_tag_t          land;

  // Search n ring slots starting at lo, beginning just after 'last'; returns {hit, index}.
  function automatic logic [PTR_W:0] rr_pick(input logic [NUM_P-1:0] req, input int last,
                                             input int lo, input int n);
    logic [PTR_W:0] r;
    int idx;
    r = '0;
    for (int k = 1; k <= n; k++) begin
      idx = lo + ((last - lo + k) % n);
      if (!r[PTR_W] && req[PTR_W'(idx)]) r = {1'b1, PTR_W'(idx)};
    end
    return r;
  endfunction

  // Eligibility: writes whenever valid, reads only while the port still holds a credit.
  always_comb begin
    elig = '0;
    for (int i = 0; i < NUM_W; i++) elig[i] = w_valid[i];
    for (int j = 0; j < NUM_R; j++) elig[NUM_W+j] = r_req_valid[j] && has_credit[j];
  end

`ifdef SRAM_ARB_STRICT_WR_PRIO_EN
  logic [PTR_W-1:0] wptr_q;
  logic [PTR_W-1:0] rptr_q;
  logic [PTR_W:0]   wpick;
  logic [PTR_W:0]   rpick;

  // Writes win outright; each class rotates on its own pointer.
  always_comb begin
    wpick = rr_pick(elig, int'(wptr_q), 0, NUM_W);
    rpick = rr_pick(elig, int'(rptr_q), NUM_W, NUM_R);
    pick  = wpick[PTR_W] ? wpick : rpick;
  end

  // Per-class pointers move only on a grant of that class.
  always_ff @(posedge sram_clock) begin
    if (reset) begin
      wptr_q <= PTR_W'(NUM_W - 1);
      rptr_q <= PTR_W'(NUM_P - 1);
    end else if (gnt_vld) begin
      if (int'(gnt_idx) < NUM_W) wptr_q <= gnt_idx;
      else                       rptr_q <= gnt_idx;
    end
  end
`else
  logic [PTR_W-1:0] ptr_q;

  assign pick = rr_pick(elig, int'(ptr_q), 0, NUM_P);

  // Single ring pointer remembers the last winner; it starts at the end so W0 goes first.
  always_ff @(posedge sram_clock) begin
    if (reset)        ptr_q <= PTR_W'(NUM_P - 1);
    else if (gnt_vld) ptr_q <= gnt_idx;
  end
`endif

  assign gnt_vld = pick[PTR_W] && sram_ready && !reset;
  assign gnt_idx = pick[PTR_W-1:0];

  // Steer the winner onto the SRAM bus; everything idles at zero without a grant.
  always_comb begin
    w_ready         = '0;
    r_req_ready     = '0;
    sram_addr_valid = 1'b0;
    sram_addr       = '0;
    sram_data_in    = '0;
    sram_write_mask = '0;
    rd_grant        = 1'b0;
    rd_id           = '0;
    if (gnt_vld) begin
      sram_addr_valid = 1'b1;
      for (int i = 0; i < NUM_W; i++) begin
        if (gnt_idx == PTR_W'(i)) begin
          w_ready[i]      = 1'b1;
          sram_write_mask = w_din[i*REQ_W + MASK_LSB +: MASK_W];
          sram_addr       = w_din[i*REQ_W + ADDR_LSB +: ADDR_W];
          sram_data_in    = w_din[i*REQ_W + DATA_LSB +: DATA_W];
        end
      end
      for (int j = 0; j < NUM_R; j++) begin
        if (gnt_idx == PTR_W'(NUM_W + j)) begin
          r_req_ready[j] = 1'b1;
          sram_addr      = r_req_addr[j*ADDR_W +: ADDR_W];
          rd_grant       = 1'b1;
          rd_id          = RID_W'(j);
        end
      end
    end
  end

  // Tag pipeline lines each returning SRAM word up with the read port that issued it.
  always_ff @(posedge sram_clock) begin
    if (reset) begin
      for (int i = 0; i < RD_LATENCY; i++) tag_q[i] <= '0;
    end else begin
      tag_q[0] <= {rd_grant, TAG_ID_W'(rd_id)};
      for (int i = 1; i < RD_LATENCY; i++) tag_q[i] <= tag_q[i-1];
    end
  end

  // Data arriving with no live tag (e.g. reads issued before a reset) is dropped here.
  assign land = tag_q[RD_LATENCY-1];

  for (genvar j = 0; j < NUM_R; j++) begin : g_port
    logic [CRED_W-1:0] credit_q;
    logic              grant_j;
    logic              push_j;
    logic              pop_j;
    logic              fifo_vld;

    assign grant_j         = rd_grant && (rd_id == RID_W'(j));
    assign push_j          = sram_data_out_valid && land.valid && (land.id == TAG_ID_W'(j)) && !reset;
    assign pop_j           = fifo_vld && r_resp_ready[j] && !reset;
    assign r_resp_valid[j] = fifo_vld && !reset;
    assign has_credit[j]   = (credit_q != '0);

    // A grant consumes a buffer slot up front; a pop hands it back.
    always_ff @(posedge sram_clock) begin
      if (reset)                    credit_q <= CRED_W'(RD_CREDITS);
      else if (grant_j && !pop_j)   credit_q <= credit_q - CRED_W'(1);
      else if (pop_j && !grant_j)   credit_q <= credit_q + CRED_W'(1);
    end

    sram_resp_fifo #(
      .DEPTH  (RD_CREDITS),
      .DATA_W (DATA_W)
    ) u_fifo (
      .sram_clock (sram_clock),
      .reset      (reset),
      .wr_valid   (push_j),
      .wr_data    (sram_data_out),
      .rd_valid   (fifo_vld),
      .rd_ready   (pop_j),
      .rd_data    (r_resp_data[j*DATA_W +: DATA_W])
    );
  end

endmodule

// File: tb/tb_sram_rr_arbiter.sv
// tb/tb_sram_rr_arbiter.sv - directed self-checking bench for sram_rr_arbiter
module tb_sram_rr_arbiter;

  localparam int NUM_W = 2;
  localparam int NUM_R = 2;
  localparam int ADDR_W = 18;
  localparam int DATA_W = 32;
  localparam int MASK_W = 4;
  localparam int REQ_W = MASK_W + ADDR_W + DATA_W;

  logic                       sram_clock = 1'b0;
  logic                       reset;
  logic [NUM_W-1:0]           w_valid;
  logic [NUM_W-1:0]           w_ready;
  logic [NUM_W*REQ_W-1:0]     w_din;
  logic [NUM_R-1:0]           r_req_valid;
  logic [NUM_R-1:0]           r_req_ready;
  logic [NUM_R*ADDR_W-1:0]    r_req_addr;
  logic [NUM_R-1:0]           r_resp_valid;
  logic [NUM_R-1:0]           r_resp_ready;
  logic [NUM_R*DATA_W-1:0]    r_resp_data;
  logic                       sram_addr_valid;
  logic                       sram_ready;
  logic [ADDR_W-1:0]          sram_addr;
  logic [DATA_W-1:0]          sram_data_in;
  logic [MASK_W-1:0]          sram_write_mask;
  logic [DATA_W-1:0]          sram_data_out;
  logic                       sram_data_out_valid;

  logic [3:0]        gnt;
  logic [2:0]        mv = '0;
  logic [ADDR_W-1:0] ma [3];
  logic              inject = 1'b0;
  int                errors = 0;
  int                checks = 0;

  localparam logic [REQ_W-1:0] W0_REQ = {4'hF, 18'h00AAA, 32'h1111_1111};
  localparam logic [REQ_W-1:0] W1_REQ = {4'h3, 18'h00BBB, 32'h2222_2222};

  sram_rr_arbiter dut (
    .sram_clock          (sram_clock),
    .reset               (reset),
    .w_valid             (w_valid),
    .w_ready             (w_ready),
    .w_din               (w_din),
    .r_req_valid         (r_req_valid),
    .r_req_ready         (r_req_ready),
    .r_req_addr          (r_req_addr),
    .r_resp_valid        (r_resp_valid),
    .r_resp_ready        (r_resp_ready),
    .r_resp_data         (r_resp_data),
    .sram_addr_valid     (sram_addr_valid),
    .sram_ready          (sram_ready),
    .sram_addr           (sram_addr),
    .sram_data_in        (sram_data_in),
    .sram_write_mask     (sram_write_mask),
    .sram_data_out       (sram_data_out),
    .sram_data_out_valid (sram_data_out_valid)
  );

  always #5 sram_clock = ~sram_clock;

  assign gnt = {r_req_ready, w_ready};

  function automatic logic [DATA_W-1:0] mem_fn(input logic [ADDR_W-1:0] a);
    return 32'hC0DE_0000 ^ {14'h0, a};
  endfunction

  // SRAM model: read data returns three cycles after the read is issued
  always @(posedge sram_clock) begin
    mv    <= {mv[1:0], sram_addr_valid & (|r_req_ready)};
    ma[0] <= sram_addr;
    ma[1] <= ma[0];
    ma[2] <= ma[1];
  end

  assign sram_data_out_valid = mv[2] | inject;
  assign sram_data_out       = inject ? 32'hDEAD_BEEF : mem_fn(ma[2]);

  task automatic tick;
    @(posedge sram_clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [3:0] ring_exp [4];
    logic [3:0] prio_exp [6];
    int         port;
`ifdef SRAM_ARB_STRICT_WR_PRIO_EN
    ring_exp = '{4'h1, 4'h2, 4'h1, 4'h2};
    prio_exp = '{4'h1, 4'h1, 4'h1, 4'h1, 4'h1, 4'h1};
`else
    ring_exp = '{4'h1, 4'h2, 4'h4, 4'h8};
    prio_exp = '{4'h8, 4'h1, 4'h4, 4'h8, 4'h1, 4'h4};
`endif

    reset        = 1'b1;
    w_valid      = '0;
    w_din        = {W1_REQ, W0_REQ};
    r_req_valid  = '0;
    r_req_addr   = {18'h00050, 18'h00040};
    r_resp_ready = '0;
    sram_ready   = 1'b1;
    tick;
    tick;

    // reset holds every output low even with all requests pending
    w_valid = 2'b11; r_req_valid = 2'b11; r_resp_ready = 2'b11;
    #1;
    check("rst_grant", 64'(gnt), 64'(0));
    check("rst_sram", 64'({sram_addr_valid, sram_addr, sram_data_in, sram_write_mask}), 64'(0));
    check("rst_resp_valid", 64'(r_resp_valid), 64'(0));
    tick;

    // full load: ring order from W0
    reset = 1'b0;
    for (int c = 0; c < 8; c++) begin
      #1;
      check($sformatf("ring_c%0d", c), 64'(gnt), 64'(ring_exp[c % 4]));
      if (c == 0) check("w0_fields", 64'({sram_addr_valid, sram_write_mask, sram_addr, sram_data_in}),
                        64'({1'b1, W0_REQ}));
`ifndef SRAM_ARB_STRICT_WR_PRIO_EN
      if (c == 2) check("r0_fields", 64'({sram_write_mask, sram_addr, sram_data_in}),
                        64'({4'h0, 18'h00040, 32'h0}));
`endif
      tick;
    end
    w_valid = '0; r_req_valid = '0;
    repeat (8) tick;

    // sram_ready low stalls arbitration without moving the pointer
    w_valid = 2'b11; r_req_valid = 2'b11;
    #1;
    check("stall_pre", 64'(gnt), 64'(1));
    tick;
    sram_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #1;
      check($sformatf("stall_c%0d", c), 64'({sram_addr_valid, gnt}), 64'(0));
      tick;
    end
    sram_ready = 1'b1;
    #1;
    check("stall_resume", 64'(gnt), 64'(2));
    tick;
    w_valid = '0; r_req_valid = '0;
    repeat (8) tick;

    // credit exhaustion on R0
    r_resp_ready = '0; r_req_valid = 2'b01;
    for (int i = 0; i < 4; i++) begin
      r_req_addr[17:0] = 18'(16 + i);
      #1;
      check($sformatf("cred_grant%0d", i), 64'({gnt, sram_addr}), 64'({4'h4, 18'(16 + i)}));
      tick;
    end
    r_req_addr[17:0] = 18'h00014;
    for (int c = 0; c < 6; c++) begin
      #1;
      check($sformatf("cred_block%0d", c), 64'(r_req_ready[0]), 64'(0));
      tick;
    end
    r_resp_ready = 2'b01;
    #1;
    check("pop1", 64'({r_resp_valid[0], gnt, r_resp_data[31:0]}), 64'({1'b1, 4'h0, mem_fn(18'h10)}));
    tick;
    r_resp_ready = '0;
    #1;
    check("regrant", 64'({gnt, sram_addr}), 64'({4'h4, 18'h00014}));
    tick;
    #1;
    check("regrant_once", 64'(gnt), 64'(0));
    tick;
    r_req_valid = '0;
    repeat (4) tick;
    r_resp_ready = 2'b01;
    for (int k = 0; k < 4; k++) begin
      #1;
      check($sformatf("cred_data%0d", k), 64'({r_resp_valid[0], r_resp_data[31:0]}),
            64'({1'b1, mem_fn(18'(17 + k))}));
      tick;
    end
    #1;
    check("cred_drained", 64'(r_resp_valid), 64'(0));

    // interleaved R1/R0 reads: each port sees its own data 4 cycles after grant
    r_resp_ready = 2'b11; r_req_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      r_req_addr = {18'(32'h200 + (k + 1) / 2), 18'(32'h100 + k / 2)};
      #1;
      if (k % 2 == 0)
        check($sformatf("il_grant%0d", k), 64'({gnt, sram_addr}), 64'({4'h8, 18'(32'h200 + k / 2)}));
      else
        check($sformatf("il_grant%0d", k), 64'({gnt, sram_addr}), 64'({4'h4, 18'(32'h100 + k / 2)}));
      tick;
    end
    r_req_valid = '0;
    for (int k = 0; k < 4; k++) begin
      #1;
      port = (k % 2 == 0) ? 1 : 0;
      check($sformatf("il_valid%0d", k), 64'(r_resp_valid), 64'((k % 2 == 0) ? 2'b10 : 2'b01));
      check($sformatf("il_data%0d", k), 64'(r_resp_data[port*DATA_W +: DATA_W]),
            64'(mem_fn(18'((port == 1 ? 32'h200 : 32'h100) + k / 2))));
      tick;
    end
    #1;
    check("il_done", 64'(r_resp_valid), 64'(0));

    // reset with two reads in flight: late returns are dropped, credits restored
    r_resp_ready = '0; r_req_valid = 2'b01; r_req_addr[17:0] = 18'h00030;
    #1;
    check("rst2_g0", 64'(gnt), 64'(4));
    tick;
    r_req_addr[17:0] = 18'h00031;
    #1;
    check("rst2_g1", 64'(gnt), 64'(4));
    tick;
    reset = 1'b1;
    #1;
    check("rst2_quiet", 64'({sram_addr_valid, gnt, r_resp_valid}), 64'(0));
    tick;
    reset = 1'b0; r_req_valid = '0;
    for (int c = 0; c < 6; c++) begin
      inject = (c == 2);
      #1;
      check($sformatf("rst2_drop%0d", c), 64'(r_resp_valid), 64'(0));
      tick;
    end
    inject = 1'b0;
    r_req_valid = 2'b01;
    for (int i = 0; i < 4; i++) begin
      r_req_addr[17:0] = 18'(32'h60 + i);
      #1;
      check($sformatf("rst2_credit%0d", i), 64'(gnt), 64'(4));
      tick;
    end
    #1;
    check("rst2_credit_limit", 64'(gnt), 64'(0));
    tick;
    r_req_valid = '0;
    repeat (4) tick;
    r_resp_ready = 2'b01;
    for (int i = 0; i < 4; i++) begin
      #1;
      check($sformatf("rst2_data%0d", i), 64'({r_resp_valid[0], r_resp_data[31:0]}),
            64'({1'b1, mem_fn(18'(32'h60 + i))}));
      tick;
    end
    #1;
    check("rst2_empty", 64'(r_resp_valid), 64'(0));

    // W0 held valid alongside both reads
    r_resp_ready = 2'b11; w_valid = 2'b01; r_req_valid = 2'b11;
    for (int c = 0; c < 6; c++) begin
      #1;
      check($sformatf("prio_c%0d", c), 64'(gnt), 64'(prio_exp[c]));
      tick;
    end
    w_valid = '0; r_req_valid = '0;
    repeat (4) tick;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sram_rr_arbiter.md
SRAM_RR_ARBITER -- requirements
Module: sram_rr_arbiter

Interface
REQ-001 SHALL have parameter NUM_W, default 2, meaning the number of write ports.
REQ-002 SHALL have parameter NUM_R, default 2, meaning the number of read ports.
REQ-003 SHALL have parameter ADDR_W, default 18, meaning the SRAM word address width.
REQ-004 SHALL have parameter DATA_W, default 32, meaning the data width; MASK_W = DATA_W/8.
REQ-005 SHALL have parameter RD_LATENCY, default 3, meaning the cycles from read issue to sram_data_out_valid.
REQ-006 SHALL have parameter RD_CREDITS, default 4, meaning the per-read-port response buffer depth.
REQ-007 SHALL have port sram_clock, input, 1 bit: the single clock for all logic.
REQ-008 SHALL have port reset, input, 1 bit: synchronous, active-high.
REQ-009 SHALL have port w_valid, input, NUM_W bits: write request per port.
REQ-010 SHALL have port w_ready, output, NUM_W bits: write accepted this cycle.
REQ-011 SHALL have port w_din, input, NUM_W*(MASK_W+ADDR_W+DATA_W) bits: per port {mask,addr,data}.
REQ-012 SHALL have ports r_req_valid (input, NUM_R), r_req_ready (output, NUM_R) and r_req_addr (input, NUM_R*ADDR_W): read address requests.
REQ-013 SHALL have ports r_resp_valid (output, NUM_R), r_resp_ready (input, NUM_R) and r_resp_data (output, NUM_R*DATA_W): read data return.
REQ-014 SHALL have SRAM-side ports sram_addr_valid (out, 1), sram_ready (in, 1), sram_addr (out, ADDR_W), sram_data_in (out, DATA_W), sram_write_mask (out, MASK_W), sram_data_out (in, DATA_W) and sram_data_out_valid (in, 1).

Function
REQ-015 SHALL treat write port i as eligible when w_valid[i]=1, and read port j as eligible when r_req_valid[j]=1 and credit[j]>0.
REQ-016 SHALL grant at most one eligible requester per cycle, and only when sram_ready=1, using a round-robin ring ordered W0..W(NUM_W-1), R0..R(NUM_R-1).
REQ-017 SHALL search the ring starting one position after the last granted requester; the pointer SHALL update only on a grant.
REQ-018 SHALL issue a grant combinationally in the same cycle: sram_addr_valid=1, sram_addr/sram_data_in/sram_write_mask from the winner, and the winner's w_ready or r_req_ready=1.
REQ-019 SHALL drive sram_write_mask=0 and sram_data_in=0 on a read grant.
REQ-020 SHALL drive sram_addr_valid=0 and all SRAM outputs to 0 when there is no grant.
REQ-021 SHALL carry a {valid, port-id} tag for each read grant through a RD_LATENCY-stage shift register.
REQ-022 SHALL write sram_data_out into the tagged port's response buffer on sram_data_out_valid.
REQ-023 SHALL hold credit[j] equal to RD_CREDITS minus (tags in flight for j plus buffer entries for j).
REQ-024 SHALL decrement credit[j] on a read grant and increment it on an r_resp pop; on a simultaneous grant and pop the count SHALL be unchanged.
REQ-025 SHALL present each response buffer FIFO-ordered with r_resp_valid = buffer non-empty; a pop SHALL occur when r_resp_valid & r_resp_ready.
REQ-026 SHALL never overflow a response buffer, as guaranteed by the credit rule.
REQ-027 SHALL return data for each port in request order, with latency RD_LATENCY+1 to r_resp_valid.

Reset
REQ-028 SHALL, while reset=1 at a sram_clock edge, set the RR pointer to the last ring position (so W0 is checked first), clear all tags, empty all buffers and set every credit to RD_CREDITS.
REQ-029 SHALL hold every ready/valid output and every SRAM output at 0 during reset.
REQ-030 SHALL discard, without writing, any sram_data_out_valid arriving in the first RD_LATENCY cycles after reset deasserts.

Configuration
REQ-031 SHALL, with SRAM_ARB_STRICT_WR_PRIO_EN defined, grant any eligible write before any read, using round-robin within each class with separate pointers.
REQ-032 SHALL, without SRAM_ARB_STRICT_WR_PRIO_EN, use the single ring of REQ-016.

Structure
REQ-033 SHALL place the request-field offsets {mask,addr,data}, the tag struct and the port-id width function in the shared package sram_arb_pkg.
REQ-034 SHALL implement each response buffer as an instance of the sub-module sram_resp_fifo, a synchronous FIFO of depth RD_CREDITS.

Verification
REQ-035 SHALL verify: all w_valid=1 and r_req_valid=1 continuously with sram_ready=1 -> grants cycle W0,W1,R0,R1,W0...; each port gets 1 grant per 4 cycles.
REQ-036 SHALL verify: R0 issues 4 reads to 0x10..0x13 with r_resp_ready=0 -> after the 4th grant r_req_ready[0] stays 0; one pop -> exactly one further grant.
REQ-037 SHALL verify: R0 and R1 reads interleaved against a RD_LATENCY=3 SRAM model -> each port receives only its own data, in order, 4 cycles after grant.
REQ-038 SHALL verify: sram_ready=0 for 5 cycles with all requests pending -> no grants, pointer unchanged; next grant is the expected ring position.
REQ-039 SHALL verify: reset asserted with 2 reads in flight -> credits return to 4, buffers empty, and late sram_data_out_valid pulses are dropped.
REQ-040 SHALL verify: with SRAM_ARB_STRICT_WR_PRIO_EN and W0 valid continuously -> R0 and R1 are never granted; with the macro undefined -> R0 is granted within 4 cycles.
